// File: rtl/shift_pipe_if.sv
// Request/result handshake bundle for shift_pipe.
// out_carry exists only when SHIFT_CARRY_EN is defined.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 32
`endif

interface shift_pipe_if #(
    parameter int N = `DEFAULT_WIDTH
);
    localparam int BW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [BW-1:0] in_b;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_zero;
`ifdef SHIFT_CARRY_EN
    logic          out_carry;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_carry
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
`endif
endinterface

// File: rtl/shift_pipe.sv
// Pipelined log-structured barrel shifter (rol/ror/lsl/lsr/asr) with valid/ready flow control.
// Define SHIFT_CARRY_EN to add out_carry, the last bit shifted out.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 32
`endif

module shift_pipe #(
    parameter int N      = `DEFAULT_WIDTH,
    parameter int STAGES = 1
) (
    input logic         clk,
    input logic         rst,
    shift_pipe_if.slave bus
);
    localparam int LVLS = $clog2(N);
    localparam int PER  = (LVLS + STAGES - 1) / STAGES;

    localparam logic [2:0] OP_ROL = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd1;
    localparam logic [2:0] OP_LSL = 3'd2;
    localparam logic [2:0] OP_LSR = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;

    typedef struct packed {
        logic            valid;
        logic [2:0]      op;
        logic [LVLS-1:0] amt;
`ifdef SHIFT_CARRY_EN
        logic            carry;
`endif
        logic [N-1:0]    data;
    } stage_t;

`ifdef SHIFT_CARRY_EN
    // After the last active level this is exactly the final bit shifted out.
    function automatic logic levelCarry(input logic [2:0] op, input logic [N-1:0] before,
                                        input logic [N-1:0] after, input int sh);
        logic [N-1:0] t;
        case (op)
            OP_ROL:  t = after;
            OP_ROR:  t = after >> (N - 1);
            OP_LSL:  t = before >> (N - sh);
            default: t = before >> (sh - 1);
        endcase
        return t[0];
    endfunction
`endif

    function automatic stage_t applyLevel(input stage_t st, input int lvl);
        stage_t          r;
        logic [LVLS-1:0] amtBits;
        int              sh;
        r       = st;
        sh      = 1 << lvl;
        amtBits = st.amt >> lvl;
        if (amtBits[0]) begin
            case (st.op)
                OP_ROL:  r.data = (st.data << sh) | (st.data >> (N - sh));
                OP_ROR:  r.data = (st.data >> sh) | (st.data << (N - sh));
                OP_LSL:  r.data = st.data << sh;
                OP_LSR:  r.data = st.data >> sh;
                OP_ASR:  r.data = $signed(st.data) >>> sh;
                default: r.data = st.data;
            endcase
`ifdef SHIFT_CARRY_EN
            if (st.op <= OP_ASR) begin
                r.carry = levelCarry(st.op, st.data, r.data, sh);
            end
`endif
        end
        return r;
    endfunction

    stage_t stQ [STAGES];
    stage_t stD [STAGES];
    logic   advance;
    logic   unusedTail;

    assign advance = !stQ[STAGES-1].valid || bus.out_ready;

    // Stage s owns levels [s*PER, (s+1)*PER); trailing stages may own none and just register.
    for (genvar s = 0; s < STAGES; s++) begin : gStage
        stage_t stIn;
        stage_t stOut;

        if (s == 0) begin : gHead
            always_comb begin
                stIn       = '0;
                stIn.valid = bus.in_valid;
                stIn.op    = bus.in_op;
                stIn.amt   = bus.in_b;
                stIn.data  = bus.in_a;
            end
        end else begin : gBody
            assign stIn = stQ[s-1];
        end

        always_comb begin
            stOut = stIn;
            for (int l = s * PER; l < (s + 1) * PER && l < LVLS; l++) begin
                stOut = applyLevel(stOut, l);
            end
        end

        assign stD[s] = stOut;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                stQ[s] <= '0;
            end
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                stQ[s] <= stD[s];
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = stQ[STAGES-1].valid;
    assign bus.out_data  = stQ[STAGES-1].data;
    assign bus.out_zero  = ~|stQ[STAGES-1].data;
`ifdef SHIFT_CARRY_EN
    assign bus.out_carry = stQ[STAGES-1].carry;
`endif

    assign unusedTail = ^{stQ[STAGES-1].op, stQ[STAGES-1].amt};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: N=8/STAGES=1 and N=32/STAGES=5 instances side by side.
// Carry checks are compiled in when SHIFT_CARRY_EN is defined.
module tb_shift_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    shift_pipe_if #(.N(8))  bus8  ();
    shift_pipe_if #(.N(32)) bus32 ();

    shift_pipe #(.N(8),  .STAGES(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    shift_pipe #(.N(32), .STAGES(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    typedef struct {
        logic [7:0] a;
        logic [2:0] b;
        logic [2:0] op;
        logic [7:0] expData;
        logic       expCarry;
        logic       expZero;
    } vec8_t;

    vec8_t       vecs [12];
    logic [32:0] expQ [$];
    logic [31:0] rnd;
    logic [32:0] expv;
    int          fa, fv, lv, nOut, validSeen;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: {carry, data} computed straight from the operation definitions on an n-bit word.
    function automatic logic [32:0] refShift(input logic [31:0] a, input int b, input int op, input int n);
        logic [63:0] mask, x, d, t;
        logic        c;
        mask = (64'd1 << n) - 64'd1;
        x    = {32'd0, a} & mask;
        d    = x;
        c    = 1'b0;
        if (b != 0) begin
            case (op)
                0: begin d = ((x << b) | (x >> (n - b))) & mask; c = d[0]; end
                1: begin d = ((x >> b) | (x << (n - b))) & mask; t = d >> (n - 1); c = t[0]; end
                2: begin d = (x << b) & mask; t = x >> (n - b); c = t[0]; end
                3: begin d = x >> b; t = x >> (b - 1); c = t[0]; end
                4: begin
                    d = x >> b;
                    t = x >> (n - 1);
                    if (t[0]) d = d | (mask & ~(mask >> b));
                    t = x >> (b - 1);
                    c = t[0];
                end
                default: ;
            endcase
        end
        return {c, d[31:0]};
    endfunction

    task automatic applyStimulus(input logic [7:0] a, input logic [2:0] b, input logic [2:0] op);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_op    = op;
        @(posedge clk);
        #1;
    endtask

    task automatic runStream32(input int count, input bit randValid, input bit randReady,
                               input int stallAt, input int stallLen,
                               output int firstAccept, output int firstValid,
                               output int lastValid, output int outCount);
        int          sent, cyc, budget;
        logic [31:0] r, held, reqA;
        logic [4:0]  reqB;
        logic [2:0]  reqOp;
        logic [32:0] e;
        bit          pending, stalling;
        sent = 0; cyc = 0; outCount = 0; pending = 0; held = '0;
        reqA = '0; reqB = '0; reqOp = '0;
        firstAccept = -1; firstValid = -1; lastValid = -1;
        budget = count * 10 + 60;
        while ((sent < count || expQ.size() != 0) && cyc < budget) begin
            @(negedge clk);
            stalling = (cyc >= stallAt) && (cyc < stallAt + stallLen);
            r = $urandom;
            if (stalling)       bus32.out_ready = 1'b0;
            else if (randReady) bus32.out_ready = (r[1:0] != 2'b00);
            else                bus32.out_ready = 1'b1;
            #1;
            if (stalling) begin
                checkOutput("stall in_ready", 64'(bus32.in_ready), 64'd0);
                checkOutput("stall out_valid", 64'(bus32.out_valid), 64'd1);
                if (cyc == stallAt) held = bus32.out_data;
                else checkOutput("stall out_data held", 64'(bus32.out_data), 64'(held));
            end
            if (bus32.out_valid) begin
                if (firstValid < 0) firstValid = cyc;
                lastValid = cyc;
                if (bus32.out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("spurious out_valid", 64'(bus32.out_valid), 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        outCount++;
                        checkOutput("stream data", 64'(bus32.out_data), 64'(e[31:0]));
                        checkOutput("stream zero", 64'(bus32.out_zero), 64'(e[31:0] == 32'd0));
`ifdef SHIFT_CARRY_EN
                        checkOutput("stream carry", 64'(bus32.out_carry), 64'(e[32]));
`endif
                    end
                end
            end
            if (!pending && sent < count) begin
                r = $urandom;
                if (!randValid || r[2:0] != 3'd0) begin
                    reqA    = $urandom;
                    r       = $urandom;
                    reqB    = r[4:0];
                    reqOp   = r[10:8];
                    pending = 1'b1;
                end
            end
            bus32.in_valid = pending;
            bus32.in_a     = reqA;
            bus32.in_b     = reqB;
            bus32.in_op    = reqOp;
            #1;
            if (pending && bus32.in_ready) begin
                expQ.push_back(refShift(reqA, int'(reqB), int'(reqOp), 32));
                sent++;
                pending = 1'b0;
                if (firstAccept < 0) firstAccept = cyc;
            end
            cyc++;
        end
        bus32.in_valid = 1'b0;
        checkOutput("stream drained", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{8'h87, 3'd3, 3'd0, 8'h3C, 1'b0, 1'b0};
        vecs[1]  = '{8'h87, 3'd3, 3'd1, 8'hF0, 1'b1, 1'b0};
        vecs[2]  = '{8'h87, 3'd3, 3'd2, 8'h38, 1'b0, 1'b0};
        vecs[3]  = '{8'h87, 3'd3, 3'd3, 8'h10, 1'b1, 1'b0};
        vecs[4]  = '{8'h87, 3'd3, 3'd4, 8'hF0, 1'b1, 1'b0};
        vecs[5]  = '{8'h5A, 3'd0, 3'd6, 8'h5A, 1'b0, 1'b0};
        vecs[6]  = '{8'hC3, 3'd5, 3'd7, 8'hC3, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 3'd2, 3'd0, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{8'h80, 3'd7, 3'd4, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{8'hFF, 3'd0, 3'd2, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{8'h01, 3'd1, 3'd1, 8'h80, 1'b1, 1'b0};
        vecs[11] = '{8'h80, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1};

        rst = 1'b1;
        bus8.in_valid  = 1'b0; bus8.in_a  = '0; bus8.in_b  = '0; bus8.in_op  = '0; bus8.out_ready  = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_op = '0; bus32.out_ready = 1'b1;
        #12;
        checkOutput("reset out_valid8", 64'(bus8.out_valid), 64'd0);
        checkOutput("reset in_ready8", 64'(bus8.in_ready), 64'd1);
        checkOutput("reset out_data8", 64'(bus8.out_data), 64'd0);
        checkOutput("reset out_zero8", 64'(bus8.out_zero), 64'd1);
        checkOutput("reset out_valid32", 64'(bus32.out_valid), 64'd0);
        checkOutput("reset out_zero32", 64'(bus32.out_zero), 64'd1);
`ifdef SHIFT_CARRY_EN
        checkOutput("reset out_carry8", 64'(bus8.out_carry), 64'd0);
`endif
        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
            checkOutput($sformatf("vec%0d valid", i), 64'(bus8.out_valid), 64'd1);
            checkOutput($sformatf("vec%0d data", i), 64'(bus8.out_data), 64'(vecs[i].expData));
            checkOutput($sformatf("vec%0d zero", i), 64'(bus8.out_zero), 64'(vecs[i].expZero));
`ifdef SHIFT_CARRY_EN
            checkOutput($sformatf("vec%0d carry", i), 64'(bus8.out_carry), 64'(vecs[i].expCarry));
`endif
        end

        for (int i = 0; i < 40; i++) begin
            rnd  = $urandom;
            expv = refShift({24'd0, rnd[7:0]}, int'(rnd[10:8]), int'(rnd[13:11]), 8);
            applyStimulus(rnd[7:0], rnd[10:8], rnd[13:11]);
            checkOutput("rand8 valid", 64'(bus8.out_valid), 64'd1);
            checkOutput("rand8 data", 64'(bus8.out_data), 64'(expv[7:0]));
            checkOutput("rand8 zero", 64'(bus8.out_zero), 64'(expv[7:0] == 8'd0));
`ifdef SHIFT_CARRY_EN
            checkOutput("rand8 carry", 64'(bus8.out_carry), 64'(expv[32]));
`endif
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;

        runStream32(10, 1'b0, 1'b0, 1000000, 0, fa, fv, lv, nOut);
        checkOutput("stream latency", 64'(fv - fa), 64'd5);
        checkOutput("stream count", 64'(nOut), 64'd10);
        checkOutput("stream consecutive", 64'(lv - fv), 64'd9);

        runStream32(15, 1'b0, 1'b0, 7, 4, fa, fv, lv, nOut);
        checkOutput("stall count", 64'(nOut), 64'd15);

        runStream32(80, 1'b1, 1'b1, 1000000, 0, fa, fv, lv, nOut);
        checkOutput("random count", 64'(nOut), 64'd80);

        expQ.delete();
        @(negedge clk);
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus32.in_valid = 1'b1;
            bus32.in_a     = 32'hF00D_0001 + i;
            bus32.in_b     = 5'd0;
            bus32.in_op    = 3'd0;
            @(negedge clk);
        end
        bus32.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("pre-reset out_valid", 64'(bus32.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid reset out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("mid reset out_zero", 64'(bus32.out_zero), 64'd1);
        checkOutput("mid reset out_data", 64'(bus32.out_data), 64'd0);
        checkOutput("mid reset in_ready", 64'(bus32.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        validSeen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus32.out_valid) validSeen++;
        end
        checkOutput("post-reset ghost results", 64'(validSeen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter N, default `DEFAULT_WIDTH, operand width; SHALL be a power of two, at least 2.
REQ-002 Parameter STAGES, default 1, number of pipeline register stages; SHALL be in the range 1..$clog2(N).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 in_a  input  N  operand.
REQ-008 in_b  input  $clog2(N)  shift amount.
REQ-009 in_op  input  3  operation: 0 = rol, 1 = ror, 2 = lsl, 3 = lsr, 4 = asr; values 5-7 are reserved.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  N  result.
REQ-013 out_zero  output  1  out_data == 0.

Function
REQ-014 Results SHALL be:
- rol/ror: rotate left/right by in_b.
- lsl/lsr: logical shift left/right by in_b, zero fill.
- asr: right shift by in_b, filling with in_a[N-1].
REQ-015 A reserved in_op SHALL produce out_data = in_a unchanged.
REQ-016 Shifting SHALL be log-structured: $clog2(N) mux levels, where level i shifts by 2^i when in_b[i] = 1.
REQ-017 A register SHALL be placed after every ceil($clog2(N)/STAGES) mux levels, and the final register SHALL drive the outputs. There SHALL be exactly STAGES registers.
REQ-018 Each stage SHALL carry a valid bit and the op/amount bits still needed downstream.
REQ-019 Latency SHALL be STAGES cycles from an accepted request to out_valid with no backpressure.
REQ-020 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-021 Stall rule: advance = !out_valid || out_ready. in_ready SHALL equal advance, and all stages SHALL move together only when advance = 1.
REQ-022 Bubbles SHALL not be collapsed: an empty stage SHALL still wait for advance.
REQ-023 A request SHALL be accepted when in_valid && in_ready. When in_valid = 0 on an advance cycle, a bubble SHALL enter stage 0.
REQ-024 While out_valid && !out_ready, out_data, out_zero, and out_carry (if present) SHALL be held stable.
REQ-025 in_b = 0 SHALL return in_a for every op.
REQ-026 in_ready SHALL depend combinationally on out_ready only; there SHALL be no path from in_valid to in_ready.

Reset
REQ-027 rst = 1 SHALL clear every stage valid bit immediately, giving out_valid = 0 and in_ready = 1.
REQ-028 On rst, out_data SHALL become 0 and out_zero SHALL become 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight requests, and none SHALL emerge afterwards.
REQ-030 The first request SHALL be accepted on the first rising edge with rst = 0.

Configuration
REQ-031 Macro SHIFT_CARRY_EN: when defined, the block SHALL add port out_carry (output, 1 bit), the last bit shifted out, registered through the pipeline alongside out_data:
- lsl: in_a[N-in_b].
- lsr/asr: in_a[in_b-1].
- rol: out_data[0].
- ror: out_data[N-1].
- in_b = 0 or reserved in_op: 0.
- Reset value: 0.
REQ-032 Without SHIFT_CARRY_EN, the out_carry port and its storage SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL cover, with N = 8 and STAGES = 1:
- in_a = 8'b10000111, in_b = 3, each op -> rol 00111100, ror 11110000, lsl 00111000, lsr 00010000, asr 11110000, one cycle later.
- With SHIFT_CARRY_EN: same inputs -> carry rol 0, ror 1, lsl 0, lsr 1, asr 1.
REQ-034 The bench SHALL cover, with N = 32 and STAGES = 5: back-to-back stream of 10 requests, out_ready = 1 -> out_valid first rises 5 cycles after the first accept, then 10 consecutive results in order.
REQ-035 The bench SHALL cover, with N = 32 and STAGES = 5: out_ready = 0 for 4 cycles while full -> in_ready = 0 and out_data stable; then out_ready = 1 -> no loss or duplication.
REQ-036 The bench SHALL cover: rst pulsed with 3 requests in flight -> out_valid = 0 immediately, out_zero = 1, and none of the 3 results ever appears.
REQ-037 The bench SHALL cover:
- in_b = 0 and in_op = 6 -> out_data = in_a.
- in_a = 0 -> out_zero = 1.
- N = 8, asr of 8'h80 by 7 -> 8'hFF.
